lcd_scan_controller: RTL and testbench

//  Time-multiplexes NUM_DIGITS hex digits onto one shared 4->7 segment decoder and one segment bus.

---
 rtl/lcd_scan_controller_pkg.sv | 18 +
 rtl/lcd_scan_controller_decoder.sv | 30 +++
 rtl/lcd_scan_controller.sv | 141 ++++++++++++++
 tb/tb_lcd_scan_controller.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/lcd_scan_controller_pkg.sv
// Shared constants, state encoding and sizing helpers for the LCD digit scanner.
package lcd_scan_controller_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  // Counter width covering the longer of the two phase lengths (at least 1 bit).
  function automatic int cnt_width(input int dwell, input int guard);
    int longest;
    longest = (dwell > guard) ? dwell : guard;
    return (longest > 1) ? $clog2(longest) : 1;
  endfunction

endpackage

// File: rtl/lcd_scan_controller_decoder.sv
// Hex nibble to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module lcd_scan_controller_decoder (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'b1111111;
    case (nibble_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0011000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/lcd_scan_controller.sv
// Round-robin multiplexed hex display scanner with blanking guard and
// frame-synchronous display update through a one-entry pending slot.
//
// state    | meaning
// ST_BLANK | all digits off for GUARD cycles (anti-ghosting gap)
// ST_DRIVE | digit idx driven for DWELL cycles
module lcd_scan_controller
  import lcd_scan_controller_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 50000,
  parameter int GUARD      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      loadValid,
  output logic                      loadReady,
  input  logic [4*NUM_DIGITS-1:0]   loadData,
  input  logic                      blankLeadZero,
  output logic [6:0]                segOut,
  output logic [NUM_DIGITS-1:0]     digitEn,
  output logic                      frameDone
);

  localparam int CW = cnt_width(DWELL, GUARD);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0]         DWELL_TC  = CW'(DWELL - 1);
  localparam logic [CW-1:0]         GUARD_TC  = CW'(GUARD - 1);
  localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] DIGIT_OFF = '1;

  scan_state_e               state_q;
  logic [CW-1:0]             cnt_q;
  logic [IW-1:0]             idx_q;
  logic [4*NUM_DIGITS-1:0]   display_q;
  logic [4*NUM_DIGITS-1:0]   pending_q;
  logic                      pend_full_q;
  logic [6:0]                seg_q;
  logic [6:0]                seg_d;
  logic [NUM_DIGITS-1:0]     dig_q;
  logic [NUM_DIGITS-1:0]     dig_d;
  logic                      frame_done_q;

  logic [3:0]                nibble;
  logic [6:0]                dec_seg;
  logic [NUM_DIGITS-1:0]     upper_zero;
  logic                      blank_digit;
  logic                      wrap;
  logic                      accept;

  assign nibble = display_q[{idx_q, 2'b00} +: 4];

  lcd_scan_controller_decoder u_decoder (
    .nibble_i (nibble),
    .seg_o    (dec_seg)
  );

  // upper_zero[i]: nibble i and every more-significant nibble are zero.
  always_comb begin
    upper_zero = '0;
    upper_zero[NUM_DIGITS-1] = (display_q[4*(NUM_DIGITS-1) +: 4] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] & (display_q[4*i +: 4] == 4'h0);
    end
  end

  assign blank_digit = blankLeadZero && (idx_q != '0) && upper_zero[idx_q];

  always_comb begin
    dig_d = DIGIT_OFF;
    seg_d = SEG_BLANK;
    if (state_q == ST_DRIVE) begin
      dig_d[idx_q] = 1'b0;
      if (!blank_digit) begin
        seg_d = dec_seg;
      end
    end
  end

  assign wrap   = (state_q == ST_DRIVE) && (cnt_q == DWELL_TC) && (idx_q == IDX_LAST);
  assign accept = loadValid && !pend_full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      display_q    <= '0;
      pending_q    <= '0;
      pend_full_q  <= 1'b0;
      seg_q        <= SEG_BLANK;
      dig_q        <= DIGIT_OFF;
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      dig_q        <= dig_d;
      frame_done_q <= wrap;

      case (state_q)
        ST_BLANK: begin
          if (cnt_q == GUARD_TC) begin
            cnt_q   <= '0;
            state_q <= ST_DRIVE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DRIVE: begin
          if (cnt_q == DWELL_TC) begin
            cnt_q   <= '0;
            state_q <= ST_BLANK;
            idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= ST_BLANK;
        end
      endcase

      // Commit only looks at the slot as it was before this edge; a value
      // accepted on the wrap cycle waits for the following frame.
      if (wrap && pend_full_q) begin
        display_q   <= pending_q;
        pend_full_q <= 1'b0;
      end else if (accept) begin
        pending_q   <= loadData;
        pend_full_q <= 1'b1;
      end
    end
  end

  assign loadReady = !pend_full_q;
  assign segOut    = seg_q;
  assign digitEn   = dig_q;
  assign frameDone = frame_done_q;

endmodule

// File: tb/tb_lcd_scan_controller.sv
// Directed bench for lcd_scan_controller with a 20-cycle frame (4 digits, dwell 4, guard 1).
module tb_lcd_scan_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        loadValid;
  logic        loadReady;
  logic [15:0] loadData;
  logic        blankLeadZero;
  logic [6:0]  segOut;
  logic [3:0]  digitEn;
  logic        frameDone;

  int checks   = 0;
  int failures = 0;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  always #5 clk = ~clk;

  lcd_scan_controller #(
    .NUM_DIGITS (4),
    .DWELL      (4),
    .GUARD      (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .loadValid     (loadValid),
    .loadReady     (loadReady),
    .loadData      (loadData),
    .blankLeadZero (blankLeadZero),
    .segOut        (segOut),
    .digitEn       (digitEn),
    .frameDone     (frameDone)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer v until it is taken; returns on the negedge after the accepting edge.
  task automatic load(input logic [15:0] v);
    logic rb;
    loadData  = v;
    loadValid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rb = loadReady;
      @(negedge clk);
      if (rb) begin
        loadValid = 1'b0;
        return;
      end
    end
    loadValid = 1'b0;
    check("load_timeout", {31'd0, loadReady}, 32'd1);
  endtask

  task automatic wait_frame_done();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (frameDone) return;
    end
    check("frame_timeout", {31'd0, frameDone}, 32'd1);
  endtask

  // Checks the 20 cycles following a frameDone cycle against the expected value.
  task automatic check_frame(input logic [15:0] v, input logic blz, input logic drop);
    logic [3:0]  exp_dig;
    logic [6:0]  exp_seg;
    logic [15:0] upper;
    logic [3:0]  nib;
    int          k;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (j == 0 && drop) begin
        check("bp_second_taken", {31'd0, loadReady}, 32'd0);
        loadValid = 1'b0;
      end
      k = j / 5;
      if (j % 5 == 0) begin
        exp_dig = 4'b1111;
        exp_seg = 7'b1111111;
      end else begin
        exp_dig = 4'b1111 ^ (4'b0001 << k);
        upper   = v >> (4 * k);
        nib     = upper[3:0];
        exp_seg = (blz && k > 0 && upper == 16'h0) ? 7'b1111111 : SEG_TBL[nib];
      end
      check($sformatf("digitEn_v%0h_c%0d", v, j), {28'd0, digitEn}, {28'd0, exp_dig});
      check($sformatf("segOut_v%0h_c%0d", v, j), {25'd0, segOut}, {25'd0, exp_seg});
      check($sformatf("frameDone_v%0h_c%0d", v, j), {31'd0, frameDone}, {31'd0, (j == 19)});
    end
  endtask

  initial begin
    rst           = 1'b1;
    loadValid     = 1'b0;
    loadData      = 16'h0;
    blankLeadZero = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_segOut",    {25'd0, segOut},    32'h7F);
    check("rst_digitEn",   {28'd0, digitEn},   32'hF);
    check("rst_loadReady", {31'd0, loadReady}, 32'd1);
    check("rst_frameDone", {31'd0, frameDone}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("first_guard_dig", {28'd0, digitEn}, 32'hF);
    @(negedge clk);
    check("first_drive_dig", {28'd0, digitEn}, 32'hE);
    check("first_drive_seg", {25'd0, segOut},  {25'd0, 7'b1000000});

    load(16'h12AF);
    check("load1_ready_low", {31'd0, loadReady}, 32'd0);
    wait_frame_done();
    check("load1_ready_back", {31'd0, loadReady}, 32'd1);
    check_frame(16'h12AF, 1'b0, 1'b0);

    blankLeadZero = 1'b1;
    load(16'h0070);
    wait_frame_done();
    check_frame(16'h0070, 1'b1, 1'b0);

    load(16'h0000);
    wait_frame_done();
    check_frame(16'h0000, 1'b1, 1'b0);

    blankLeadZero = 1'b0;
    load(16'h1111);
    loadData  = 16'h2222;
    loadValid = 1'b1;
    @(negedge clk);
    check("bp_held", {31'd0, loadReady}, 32'd0);
    wait_frame_done();
    check("bp_ready_after_commit", {31'd0, loadReady}, 32'd1);
    check_frame(16'h1111, 1'b0, 1'b1);
    wait_frame_done();
    check_frame(16'h2222, 1'b0, 1'b0);

    load(16'h5678);
    check("mid_pending_full", {31'd0, loadReady}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      if (digitEn == 4'b1011) break;
      @(negedge clk);
    end
    check("mid_reached_d2", {28'd0, digitEn}, 32'hB);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready",   {31'd0, loadReady}, 32'd1);
    check("mid_rst_digitEn", {28'd0, digitEn},   32'hF);
    check("mid_rst_segOut",  {25'd0, segOut},    32'h7F);
    wait_frame_done();
    check_frame(16'h0000, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
